layer_compositor: RTL
=====================

Name: layer_compositor

Overview:
- Parametrised successor of the fixed-priority VGA objects mux.
- Selects the highest-priority active drawing layer per pixel from NUM_LAYERS inputs, with background fallback.
- Adds per-layer enable and blink control, transparent colour-key, frame-synchronous shadow configuration and a 2-stage output pipeline.
- Sits between the object drawers and the VGA controller; output is expanded RGB332 to 8-bit R/G/B.

Parameters:
- NUM_LAYERS, 10: number of object layers. Layer 0 has the highest priority.
- BLINK_DIV, 16: frames per blink half-period, range 1..255.
- TRANSPARENT, 8'hFF: RGB332 colour key. A layer pixel with this value is treated as not drawn.

Ports:
- CLK  in  1  pixel clock.
- RESETn  in  1  asynchronous active-low reset.
- draw_req  in  NUM_LAYERS  per-layer drawing request. Bit i belongs to layer i.
- layer_rgb  in  NUM_LAYERS*8  per-layer RGB332. Layer i occupies bits [8i+7:8i].
- bckgrnd_rgb  in  8  background RGB332.
- frame_start  in  1  one-cycle pulse at the first pixel of each frame.
- cfg_we  in  1  configuration write strobe.
- cfg_layer  in  $clog2(NUM_LAYERS)  layer index to configure.
- cfg_enable  in  1  enable value to write.
- cfg_blink  in  1  blink value to write.
- m_mVGA_R  out  8  red output.
- m_mVGA_G  out  8  green output.
- m_mVGA_B  out  8  blue output.
- hit_id  out  $clog2(NUM_LAYERS+1)  winning layer index. NUM_LAYERS means background.

Behaviour:
- Reset values:
  - pending and active enable registers all 1; pending and active blink registers all 0.
  - blink counter 0; blink_phase 0.
  - pipeline colour registers 0; m_mVGA_R/G/B 0.
  - hit_id = NUM_LAYERS.
  - Reset mid-frame takes effect immediately and asynchronously.
- Configuration writes:
  - On cfg_we, pending_en[cfg_layer] <= cfg_enable and pending_blk[cfg_layer] <= cfg_blink.
  - cfg_layer >= NUM_LAYERS: write ignored.
- Shadow copy: on frame_start, active_en <= pending_en and active_blk <= pending_blk.
  - If cfg_we and frame_start occur in the same cycle, active takes the old pending value.
  - That write becomes active at the next frame_start.
- Blink timer:
  - Advances on each frame_start.
  - At BLINK_DIV-1 it wraps to 0 and toggles blink_phase.
  - BLINK_DIV = 1 toggles blink_phase every frame.
- Qualification: qual[i] = draw_req[i] & active_en[i] & ~(active_blk[i] & blink_phase) & (layer_rgb_i != TRANSPARENT).
- Stage 1 (cycle N+1): register winner = lowest i with qual[i], together with its colour.
  - If no layer qualifies, winner = NUM_LAYERS and the colour is bckgrnd_rgb.
  - The background colour is not colour-keyed.
- Stage 2 (cycle N+2): register the outputs from the stage-1 colour c:
  - R = {c[7:5], 5'b0}
  - G = {c[4:2], 5'b0}
  - B = {c[1:0], 6'b0}
  - hit_id follows at the same cycle.
- Latency: exactly 2 cycles from inputs to outputs.
  - The pipeline is fully streaming, one pixel per cycle, with no stall.
- Config timing: configuration and blink state used in cycle N are the values registered before the CLK edge at N.
  - A frame_start pixel therefore uses the pre-copy active configuration.

Decomposition:
- Package compositor_pkg contains:
  - typedef rgb332_t (8 bits);
  - constant TRANSPARENT_DEFAULT = 8'hFF;
  - function expand_rgb332 returning the R/G/B 8-bit triple;
  - localparam function for the hit_id width.
- Sub-module blink_timer holds the frame counter and blink_phase.
  - Ports: CLK, RESETn, frame_start, blink_phase; parameter BLINK_DIV.
- Winner select is a for-loop priority scan inside layer_compositor.

Test Plan:
- Reset, then draw_req=0, bckgrnd_rgb=8'h1C -> two cycles later G=8'hE0, R=B=0, hit_id=NUM_LAYERS.
- draw_req[2] and draw_req[5] set, layer2=8'hE0, layer5=8'h03 -> R=8'hE0, G=0, B=0, hit_id=2 at cycle N+2.
- layer0=8'hFF with draw_req[0], draw_req[1] set, layer1=8'h03 -> transparency skips layer 0: B=8'hC0, hit_id=1.
- Write cfg_layer=1, cfg_enable=0 mid-frame -> layer 1 still wins until the cycle after the next frame_start, then falls through to the next layer or background.
- cfg_blink=1 on layer 3, BLINK_DIV=2, 8 frame_start pulses -> layer 3 visible for frames 0-1, hidden for 2-3, visible for 4-5, hidden for 6-7; hidden frames show background.
- cfg_we and frame_start in the same cycle, disabling layer 0 -> layer 0 still visible for the whole next frame, hidden after the following frame_start.
- Assert RESETn low during streaming -> outputs 0 and hit_id=NUM_LAYERS immediately; enables all 1 after release.

Source files
------------

// File: rtl/compositor_pkg.sv
// compositor_pkg: shared types and helpers for the layer compositor.
//   rgb332_t            packed RGB332 pixel
//   rgb888_t            expanded 8-bit R/G/B triple
//   TRANSPARENT_DEFAULT default colour key
//   expand_rgb332()     RGB332 -> 8-bit R/G/B with zero-filled LSBs
//   hit_w()             width of the winner index (NUM_LAYERS means background)
package compositor_pkg;
  typedef logic [7:0] rgb332_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;
  localparam rgb332_t TRANSPARENT_DEFAULT = 8'hFF;
  function automatic rgb888_t expand_rgb332(input rgb332_t c);
    return {c[7:5], 5'b0, c[4:2], 5'b0, c[1:0], 6'b0};
  endfunction
  function automatic int hit_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/blink_timer.sv
// blink_timer: frame counter toggling blink_phase every BLINK_DIV frames.
//   CLK, RESETn  pixel clock, async active-low reset
//   frame_start  one-cycle pulse per frame; advances the counter
//   blink_phase  1 while blinking layers are hidden
module blink_timer #(
  parameter int BLINK_DIV = 16
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic frame_start,
  output logic blink_phase
);
  logic [7:0] cnt_q, cnt_d;
  logic       wrap;
  always_comb begin
    wrap  = cnt_q == 8'(BLINK_DIV - 1);
    cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
  end
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      cnt_q       <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      cnt_q       <= cnt_d;
      blink_phase <= blink_phase ^ wrap;
    end
endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: per-pixel priority mux of NUM_LAYERS drawing layers over a background.
//   CLK, RESETn            pixel clock, async active-low reset
//   draw_req, layer_rgb    per-layer request and RGB332 colour (layer 0 highest priority)
//   bckgrnd_rgb            fallback colour, never colour-keyed
//   frame_start            frame pulse: shadow config copy and blink timing
//   cfg_we/layer/enable/blink  pending per-layer configuration write
//   m_mVGA_R/G/B, hit_id   expanded colour and winning layer, 2 cycles after input
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int      NUM_LAYERS  = 10,
  parameter int      BLINK_DIV   = 16,
  parameter rgb332_t TRANSPARENT = TRANSPARENT_DEFAULT
) (
  input  logic                            CLK,
  input  logic                            RESETn,
  input  logic [NUM_LAYERS-1:0]           draw_req,
  input  logic [NUM_LAYERS*8-1:0]         layer_rgb,
  input  logic [7:0]                      bckgrnd_rgb,
  input  logic                            frame_start,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_LAYERS)-1:0]   cfg_layer,
  input  logic                            cfg_enable,
  input  logic                            cfg_blink,
  output logic [7:0]                      m_mVGA_R,
  output logic [7:0]                      m_mVGA_G,
  output logic [7:0]                      m_mVGA_B,
  output logic [hit_w(NUM_LAYERS)-1:0]    hit_id
);
  localparam int HW = hit_w(NUM_LAYERS);
  logic [NUM_LAYERS-1:0] pend_en_q, pend_en_d, pend_blk_q, pend_blk_d;
  logic [NUM_LAYERS-1:0] act_en_q, act_blk_q, qual;
  logic [HW-1:0]         win_q, win_d;
  rgb332_t               col_q, col_d;
  logic                  blink_phase;
  blink_timer #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .frame_start(frame_start),
    .blink_phase(blink_phase)
  );
  always_comb begin
    pend_en_d  = pend_en_q;
    pend_blk_d = pend_blk_q;
    if (cfg_we && int'(cfg_layer) < NUM_LAYERS) begin
      pend_en_d[cfg_layer]  = cfg_enable;
      pend_blk_d[cfg_layer] = cfg_blink;
    end
  end
  // Scan from lowest priority upwards so the lowest qualifying index is the last writer.
  always_comb begin
    qual  = '0;
    win_d = HW'(NUM_LAYERS);
    col_d = bckgrnd_rgb;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      qual[i] = draw_req[i] & act_en_q[i] & ~(act_blk_q[i] & blink_phase)
              & (layer_rgb[8*i+:8] != TRANSPARENT);
      if (qual[i]) begin
        win_d = HW'(i);
        col_d = layer_rgb[8*i+:8];
      end
    end
  end
  // The shadow copy reads the pending registers before this edge's write lands,
  // so a write coinciding with frame_start waits for the following frame.
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      pend_en_q                        <= '1;
      pend_blk_q                       <= '0;
      act_en_q                         <= '1;
      act_blk_q                        <= '0;
      win_q                            <= HW'(NUM_LAYERS);
      col_q                            <= '0;
      {m_mVGA_R, m_mVGA_G, m_mVGA_B}   <= '0;
      hit_id                           <= HW'(NUM_LAYERS);
    end else begin
      pend_en_q  <= pend_en_d;
      pend_blk_q <= pend_blk_d;
      if (frame_start) begin
        act_en_q  <= pend_en_q;
        act_blk_q <= pend_blk_q;
      end
      win_q                          <= win_d;
      col_q                          <= col_d;
      {m_mVGA_R, m_mVGA_G, m_mVGA_B} <= expand_rgb332(col_q);
      hit_id                         <= win_q;
    end
endmodule
